// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman decoder: codebook entry layout,
// FSM states and mask/length conversion helpers.
package huff_pkg;
    localparam int NSYM   = 3;
    localparam int MAXLEN = 3;
    localparam int SYMW   = 8;

    typedef struct packed {
        logic [SYMW-1:0]   sym;
        logic [MAXLEN-1:0] code;
        logic [1:0]        len;
    } code_entry_t;

    typedef enum logic [1:0] {
        LOAD_SYM,
        LOAD_CODE,
        DECODE
    } state_t;

    // Only right-aligned contiguous masks are legal codes; anything else is length 0.
    function automatic logic [1:0] mask_to_len(input logic [MAXLEN-1:0] mask);
        case (mask)
            3'b001:  return 2'd1;
            3'b011:  return 2'd2;
            3'b111:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [MAXLEN-1:0] len_to_mask(input logic [1:0] len);
        case (len)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction
endpackage

// File: rtl/huff_decoder_if.sv
// 12-bit pin envelope shared with the encoder: packed control/data in, status/symbol out.
interface huff_decoder_if;
    logic [11:0] io_in;
    logic [11:0] io_out;

    modport master (output io_in, input  io_out);
    modport slave  (input  io_in, output io_out);
endinterface

// File: rtl/huff_code_match.sv
// Combinational codebook lookup: finds the lowest-index valid entry whose
// length equals the bit count and whose code equals the low bits of the accumulator.
module huff_code_match
    import huff_pkg::*;
(
    input  code_entry_t       tbl [NSYM],
    input  logic [MAXLEN-1:0] acc_next,
    input  logic [1:0]        n_next,
    output logic              hit,
    output logic [1:0]        hit_idx
);
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (tbl[i].len != 2'd0 && tbl[i].len == n_next &&
                (acc_next & len_to_mask(n_next)) == tbl[i].code) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end
endmodule

// File: rtl/huff_decoder.sv
// Huffman decoder: loads a small codebook over the pin bus, then decodes a
// serial MSB-first bitstream into symbols with registered pulse outputs.
//
// state     | meaning
// LOAD_SYM  | waiting for wr carrying the symbol byte of entry idx
// LOAD_CODE | waiting for wr carrying {mask, value} of entry idx
// DECODE    | shifting stream bits and matching against the table
module huff_decoder
    import huff_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    huff_decoder_if.slave bus
);
    logic            wr, bit_valid, reload, bit_in;
    logic [7:0]      data;

    assign data      = bus.io_in[7:0];
    assign bit_in    = bus.io_in[8];
    assign reload    = bus.io_in[9];
    assign bit_valid = bus.io_in[10];
    assign wr        = bus.io_in[11];

    state_t            state, state_nxt;
    code_entry_t       tbl [NSYM];
    code_entry_t       tbl_nxt [NSYM];
    logic [1:0]        idx, idx_nxt;
    logic [MAXLEN-1:0] acc, acc_nxt, acc_cand;
    logic [1:0]        n, n_nxt, n_cand;
    logic [SYMW-1:0]   symbol, symbol_nxt;
    logic              sym_valid, sym_valid_nxt;
    logic              code_err, code_err_nxt;
    logic              cfg_err, cfg_err_nxt;
    logic              ready, ready_nxt;
    logic              hit;
    logic [1:0]        hit_idx;
    logic [1:0]        new_len;

    assign acc_cand = {acc[MAXLEN-2:0], bit_in};
    assign n_cand   = n + 2'd1;
    assign new_len  = mask_to_len(data[5:3]);

    huff_code_match u_match (
        .tbl      (tbl),
        .acc_next (acc_cand),
        .n_next   (n_cand),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    always_comb begin
        state_nxt     = state;
        tbl_nxt       = tbl;
        idx_nxt       = idx;
        acc_nxt       = acc;
        n_nxt         = n;
        symbol_nxt    = symbol;
        sym_valid_nxt = 1'b0;
        code_err_nxt  = 1'b0;
        cfg_err_nxt   = cfg_err;
        ready_nxt     = ready;
        case (state)
            LOAD_SYM: begin
                if (wr) begin
                    tbl_nxt[idx].sym = data;
                    state_nxt        = LOAD_CODE;
                end
            end
            LOAD_CODE: begin
                if (wr) begin
                    tbl_nxt[idx].len  = new_len;
                    tbl_nxt[idx].code = data[2:0] & data[5:3];
                    if (new_len == 2'd0)
                        cfg_err_nxt = 1'b1;
                    if (idx == 2'(NSYM - 1)) begin
                        idx_nxt   = 2'd0;
                        ready_nxt = 1'b1;
                        state_nxt = DECODE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = LOAD_SYM;
                    end
                end
            end
            DECODE: begin
                if (reload) begin
                    for (int i = 0; i < NSYM; i++)
                        tbl_nxt[i].len = 2'd0;
                    idx_nxt     = 2'd0;
                    acc_nxt     = '0;
                    n_nxt       = 2'd0;
                    cfg_err_nxt = 1'b0;
                    ready_nxt   = 1'b0;
                    state_nxt   = LOAD_SYM;
                end else if (bit_valid) begin
                    if (hit) begin
                        symbol_nxt    = tbl[hit_idx].sym;
                        sym_valid_nxt = 1'b1;
                        acc_nxt       = '0;
                        n_nxt         = 2'd0;
                    end else if (n_cand == 2'(MAXLEN)) begin
                        code_err_nxt = 1'b1;
                        acc_nxt      = '0;
                        n_nxt        = 2'd0;
                    end else begin
                        acc_nxt = acc_cand;
                        n_nxt   = n_cand;
                    end
                end
            end
            default: state_nxt = LOAD_SYM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD_SYM;
            tbl       <= '{default: '0};
            idx       <= 2'd0;
            acc       <= '0;
            n         <= 2'd0;
            symbol    <= '0;
            sym_valid <= 1'b0;
            code_err  <= 1'b0;
            cfg_err   <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= state_nxt;
            tbl       <= tbl_nxt;
            idx       <= idx_nxt;
            acc       <= acc_nxt;
            n         <= n_nxt;
            symbol    <= symbol_nxt;
            sym_valid <= sym_valid_nxt;
            code_err  <= code_err_nxt;
            cfg_err   <= cfg_err_nxt;
            ready     <= ready_nxt;
        end
    end

    assign bus.io_out = {ready, cfg_err, code_err, sym_valid, symbol};
endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: a vector table for load/decode/gap behaviour
// plus hand sequences for illegal codes, illegal masks, reload and reset.
module tb_huff_decoder;
    logic clk = 1'b0;
    logic reset;

    huff_decoder_if bus ();

    huff_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] io_in;
        logic [11:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [11:0] wr_(input logic [7:0] d);
        return {1'b1, 1'b0, 1'b0, 1'b0, d};
    endfunction

    function automatic logic [11:0] bit_(input logic b);
        return {1'b0, 1'b1, 1'b0, b, 8'h00};
    endfunction

    localparam logic [11:0] IDLE = 12'h000;

    task automatic cyc(input logic [11:0] in, input logic [11:0] exp, input string name);
        bus.io_in = in;
        @(posedge clk);
        #1;
        total++;
        if (bus.io_out !== exp) begin
            bad++;
            $display("FAIL %s: io_out=%h expected=%h", name, bus.io_out, exp);
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        cyc(IDLE, 12'h000, name);
        reset = 1'b0;
    endtask

    initial begin
        bus.io_in = IDLE;
        reset     = 1'b1;
        @(posedge clk);
        do_reset("reset_state");

        // Table A=0/1, B=10/2, C=11/2, decode 1,0,0,1,1 then a gapped 'B'.
        vt.push_back('{wr_(8'h41), 12'h000});
        vt.push_back('{wr_(8'h08), 12'h000});
        vt.push_back('{wr_(8'h42), 12'h000});
        vt.push_back('{wr_(8'h1A), 12'h000});
        vt.push_back('{wr_(8'h43), 12'h000});
        vt.push_back('{wr_(8'h1B), 12'h800});
        vt.push_back('{bit_(1'b1), 12'h800});
        vt.push_back('{bit_(1'b0), 12'h942});
        vt.push_back('{bit_(1'b0), 12'h941});
        vt.push_back('{bit_(1'b1), 12'h841});
        vt.push_back('{bit_(1'b1), 12'h943});
        vt.push_back('{IDLE,       12'h843});
        vt.push_back('{wr_(8'hFF), 12'h843});
        vt.push_back('{bit_(1'b1), 12'h843});
        vt.push_back('{IDLE,       12'h843});
        vt.push_back('{IDLE,       12'h843});
        vt.push_back('{IDLE,       12'h843});
        vt.push_back('{bit_(1'b0), 12'h942});
        vt.push_back('{IDLE,       12'h842});
        for (int i = 0; i < vt.size(); i++)
            cyc(vt[i].io_in, vt[i].exp, $sformatf("vec[%0d]", i));

        // Illegal codeword: all codes are 2 bits, 1,1,1 runs off the end.
        do_reset("t3_reset");
        cyc(wr_(8'h41), 12'h000, "t3_ld0");
        cyc(wr_(8'h18), 12'h000, "t3_ld1");
        cyc(wr_(8'h42), 12'h000, "t3_ld2");
        cyc(wr_(8'h19), 12'h000, "t3_ld3");
        cyc(wr_(8'h43), 12'h000, "t3_ld4");
        cyc(wr_(8'h1A), 12'h800, "t3_ready");
        cyc(bit_(1'b1), 12'h800, "t3_b1");
        cyc(bit_(1'b1), 12'h800, "t3_b2");
        cyc(bit_(1'b1), 12'hA00, "t3_code_err");
        cyc(bit_(1'b0), 12'h800, "t3_b4");
        cyc(bit_(1'b1), 12'h942, "t3_resync_B");

        // Illegal mask 101: sticky cfg_err, then reload beats a completing bit.
        do_reset("t4_reset");
        cyc(wr_(8'h41), 12'h000, "t4_ld0");
        cyc(wr_(8'h28), 12'h400, "t4_cfg_err");
        cyc(wr_(8'h42), 12'h400, "t4_ld2");
        cyc(wr_(8'h19), 12'h400, "t4_ld3");
        cyc(wr_(8'h43), 12'h400, "t4_ld4");
        cyc(wr_(8'h1A), 12'hC00, "t4_ready_cfg");
        cyc(bit_(1'b0), 12'hC00, "t4_b0");
        cyc({1'b0, 1'b1, 1'b1, 1'b1, 8'h00}, 12'h000, "t4_reload");
        cyc(bit_(1'b1), 12'h000, "t4_bit_in_load");

        // Empty table: every third bit is a code error.
        do_reset("t6_reset");
        cyc(wr_(8'h41), 12'h000, "t6_ld0");
        cyc(wr_(8'h00), 12'h400, "t6_ld1");
        cyc(wr_(8'h42), 12'h400, "t6_ld2");
        cyc(wr_(8'h00), 12'h400, "t6_ld3");
        cyc(wr_(8'h43), 12'h400, "t6_ld4");
        cyc(wr_(8'h00), 12'hC00, "t6_ready");
        cyc(bit_(1'b0), 12'hC00, "t6_b1");
        cyc(bit_(1'b0), 12'hC00, "t6_b2");
        cyc(bit_(1'b0), 12'hE00, "t6_err");
        cyc(bit_(1'b0), 12'hC00, "t6_b4");

        // Reset in the middle of a 2-bit code.
        do_reset("t5_reset0");
        cyc(wr_(8'h41), 12'h000, "t5_ld0");
        cyc(wr_(8'h08), 12'h000, "t5_ld1");
        cyc(wr_(8'h42), 12'h000, "t5_ld2");
        cyc(wr_(8'h1A), 12'h000, "t5_ld3");
        cyc(wr_(8'h43), 12'h000, "t5_ld4");
        cyc(wr_(8'h1B), 12'h800, "t5_ready");
        cyc(bit_(1'b1), 12'h800, "t5_half_code");
        do_reset("t5_mid_reset");
        cyc(bit_(1'b1), 12'h000, "t5_bit_ignored");
        cyc(wr_(8'h41), 12'h000, "t5_rl0");
        cyc(wr_(8'h08), 12'h000, "t5_rl1");
        cyc(wr_(8'h42), 12'h000, "t5_rl2");
        cyc(wr_(8'h1A), 12'h000, "t5_rl3");
        cyc(wr_(8'h43), 12'h000, "t5_rl4");
        cyc(wr_(8'h1B), 12'h800, "t5_reready");
        cyc(bit_(1'b1), 12'h800, "t5_c1");
        cyc(bit_(1'b1), 12'h943, "t5_C");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
